// File: rtl/pkg_rv32_types.sv
// rtl/pkg_rv32_types.sv - AHB-Lite transfer/burst encodings and burst length helper
package pkg_rv32_types;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   // Beat count of a burst; 0 marks the undefined-length INCR burst
   function automatic logic [4:0] burst_len(input hburst_e hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
         HBURST_INCR:                  burst_len = 5'd0;
         default:                      burst_len = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/rv32_rr_arbiter.sv
// rtl/rv32_rr_arbiter.sv - round-robin next-owner selection, parks on master 0
module rv32_rr_arbiter #(
   parameter int NUM_M = 2,
   parameter int OW    = 1
) (
   input  logic [NUM_M-1:0] req,
   input  logic [OW-1:0]    cur,
   output logic [OW-1:0]    nxt
);

   int   idx;
   logic found;

   // Scan from cur+1 around to cur itself, so cur wins only as sole requester
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_M; i++) begin
         idx = (int'(cur) + i) % NUM_M;
         if (!found && req[OW'(idx)]) begin
            found = 1'b1;
            nxt   = OW'(idx);
         end
      end
   end

endmodule

// File: rtl/rv32_ahb_bus_arbiter.sv
// rtl/rv32_ahb_bus_arbiter.sv - AHB-Lite multi-master arbiter; AHB_ARB_HOLD_LIMIT_EN enables the INCR hold limiter
module rv32_ahb_bus_arbiter
   import pkg_rv32_types::*;
#(
   parameter int NUM_M    = 2,
   parameter int HOLD_MAX = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_busreq,
   input  logic [NUM_M*32-1:0] m_haddr,
   input  logic [NUM_M*2-1:0]  m_htrans,
   input  logic [NUM_M-1:0]    m_hwrite,
   input  logic [NUM_M*3-1:0]  m_hsize,
   input  logic [NUM_M*3-1:0]  m_hburst,
   input  logic [NUM_M*4-1:0]  m_hprot,
   input  logic [NUM_M*32-1:0] m_hwdata,
   output logic [NUM_M-1:0]    m_hgrant,
   output logic [NUM_M-1:0]    m_hready,
   output logic [NUM_M-1:0]    m_hresp,
   output logic [31:0]         s_haddr,
   output logic [1:0]          s_htrans,
   output logic                s_hwrite,
   output logic [2:0]          s_hsize,
   output logic [2:0]          s_hburst,
   output logic [3:0]          s_hprot,
   output logic [31:0]         s_hwdata,
   input  logic                s_hready,
   input  logic                s_hresp
);

   localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   if (HOLD_MAX < 1) begin : g_hold_max_range
      $error("HOLD_MAX must be positive");
   end

   logic [31:0] haddr_a  [NUM_M];
   logic [1:0]  htrans_a [NUM_M];
   logic [2:0]  hsize_a  [NUM_M];
   logic [2:0]  hburst_a [NUM_M];
   logic [3:0]  hprot_a  [NUM_M];
   logic [31:0] hwdata_a [NUM_M];

   logic [OW-1:0] own, dp_own, rr_own;
   logic          dp_valid, lock, lock_incr, lock_nxt, lock_incr_nxt;
   logic [3:0]    beat_cnt, cnt_nxt;
   htrans_e       own_trans;
   hburst_e       own_burst;
   logic          beat_live;

   for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
      assign haddr_a[g]  = m_haddr[32*g +: 32];
      assign htrans_a[g] = m_htrans[2*g +: 2];
      assign hsize_a[g]  = m_hsize[3*g +: 3];
      assign hburst_a[g] = m_hburst[3*g +: 3];
      assign hprot_a[g]  = m_hprot[4*g +: 4];
      assign hwdata_a[g] = m_hwdata[32*g +: 32];
   end

   // Owner's transfer type; a master that dropped its request is seen as IDLE
   always_comb begin
      own_trans = m_busreq[own] ? htrans_e'(htrans_a[own]) : HTRANS_IDLE;
      own_burst = hburst_e'(hburst_a[own]);
   end

   assign beat_live = (own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ);

   rv32_rr_arbiter #(.NUM_M(NUM_M), .OW(OW)) u_rr (
      .req (m_busreq),
      .cur (own),
      .nxt (rr_own)
   );

`ifdef AHB_ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(HOLD_MAX + 1);
   logic [HW-1:0] hold_cnt;
   logic          hold_inc, hold_expire;

   assign hold_inc    = lock && lock_incr && ((m_busreq & ~m_hgrant) != '0);
   assign hold_expire = hold_inc && (hold_cnt >= HW'(HOLD_MAX - 1));

   // Count contested INCR-lock cycles, restarting whenever ownership moves
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (s_hready) begin
         if (!lock_nxt && (rr_own != own))
            hold_cnt <= '0;
         else if (hold_inc && (hold_cnt < HW'(HOLD_MAX)))
            hold_cnt <= hold_cnt + 1'b1;
      end
   end
`endif

   // Next burst-lock state as seen at an accepting edge
   always_comb begin
      lock_nxt      = lock;
      lock_incr_nxt = lock_incr;
      cnt_nxt       = beat_cnt;
      case (own_trans)
         HTRANS_NONSEQ: begin
            lock_nxt      = (own_burst != HBURST_SINGLE);
            lock_incr_nxt = (own_burst == HBURST_INCR);
            cnt_nxt       = '0;
            if (burst_len(own_burst) > 5'd1)
               cnt_nxt = 4'(burst_len(own_burst) - 5'd1);
         end
         HTRANS_SEQ: begin
            if (lock && !lock_incr && (beat_cnt != 4'd0)) begin
               cnt_nxt  = beat_cnt - 4'd1;
               lock_nxt = (beat_cnt != 4'd1);
            end
         end
         HTRANS_IDLE: begin
            if (lock_incr) begin
               lock_nxt      = 1'b0;
               lock_incr_nxt = 1'b0;
            end
         end
         default: ;
      endcase
`ifdef AHB_ARB_HOLD_LIMIT_EN
      if (hold_expire && lock_incr_nxt) begin
         lock_nxt      = 1'b0;
         lock_incr_nxt = 1'b0;
      end
`endif
   end

   // Ownership, data-phase tracking and lock; a stalled slave freezes all of it
   always_ff @(posedge clk) begin
      if (rst) begin
         own       <= '0;
         dp_own    <= '0;
         dp_valid  <= 1'b0;
         lock      <= 1'b0;
         lock_incr <= 1'b0;
         beat_cnt  <= '0;
      end else if (s_hready) begin
         dp_valid  <= beat_live;
         if (beat_live)
            dp_own <= own;
         lock      <= lock_nxt;
         lock_incr <= lock_incr_nxt;
         beat_cnt  <= cnt_nxt;
         if (!lock_nxt)
            own <= rr_own;
      end else if (s_hresp) begin
         lock      <= 1'b0;
         lock_incr <= 1'b0;
         beat_cnt  <= '0;
      end
   end

   // Slave-side mux, held at reset values while rst is asserted
   always_comb begin
      s_haddr  = rst ? 32'd0 : haddr_a[own];
      s_htrans = rst ? HTRANS_IDLE : own_trans;
      s_hwrite = rst ? 1'b0  : m_hwrite[own];
      s_hsize  = rst ? 3'd0  : hsize_a[own];
      s_hburst = rst ? 3'd0  : hburst_a[own];
      s_hprot  = rst ? 4'd0  : hprot_a[own];
      s_hwdata = rst ? 32'd0 : hwdata_a[dp_own];
   end

   // Grant, ready and response fan-out to the masters
   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         m_hgrant[i] = (own == OW'(i));
         m_hready[i] = rst | (s_hready & ((own == OW'(i)) | (dp_valid & (dp_own == OW'(i)))));
         m_hresp[i]  = ~rst & s_hresp & dp_valid & (dp_own == OW'(i));
      end
   end

endmodule

// File: tb/tb_rv32_ahb_bus_arbiter.sv
// tb/tb_rv32_ahb_bus_arbiter.sv - bench for rv32_ahb_bus_arbiter (AHB_ARB_HOLD_LIMIT_EN aware)
module tb_rv32_ahb_bus_arbiter;

`ifdef AHB_ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif
   localparam int HOLD_MAX = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_busreq;
   logic [31:0] b_addr  [2];
   logic [1:0]  b_trans [2];
   logic        b_write [2];
   logic [2:0]  b_size  [2];
   logic [2:0]  b_burst [2];
   logic [3:0]  b_prot  [2];
   logic [31:0] b_wdata [2];
   logic [63:0] m_haddr, m_hwdata;
   logic [3:0]  m_htrans;
   logic [1:0]  m_hwrite;
   logic [5:0]  m_hsize, m_hburst;
   logic [7:0]  m_hprot;
   logic [1:0]  m_hgrant, m_hready, m_hresp;
   logic [31:0] s_haddr, s_hwdata;
   logic [1:0]  s_htrans;
   logic        s_hwrite;
   logic [2:0]  s_hsize, s_hburst;
   logic [3:0]  s_hprot;
   logic        s_hready, s_hresp;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int md_owner, md_dp_owner, md_beats, md_hold;
   bit md_dp_valid, md_fixed, md_incr;
   int blen [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

   assign m_haddr  = {b_addr[1], b_addr[0]};
   assign m_hwdata = {b_wdata[1], b_wdata[0]};
   assign m_htrans = {b_trans[1], b_trans[0]};
   assign m_hwrite = {b_write[1], b_write[0]};
   assign m_hsize  = {b_size[1], b_size[0]};
   assign m_hburst = {b_burst[1], b_burst[0]};
   assign m_hprot  = {b_prot[1], b_prot[0]};

   always #5 clk = ~clk;

   rv32_ahb_bus_arbiter #(.NUM_M(2), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst(rst),
      .m_busreq(m_busreq), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
      .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
      .m_hgrant(m_hgrant), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
      .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
      .s_hready(s_hready), .s_hresp(s_hresp)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic set_m(input int i, input bit req, input logic [1:0] tr, input logic [2:0] bu,
                        input logic [31:0] a, input logic [31:0] wd);
      m_busreq[i] = req;
      b_trans[i]  = tr;
      b_burst[i]  = bu;
      b_addr[i]   = a;
      b_wdata[i]  = wd;
   endtask

   function automatic int rr_pick(input int cur, input logic [1:0] req);
      for (int k = 1; k <= 2; k++)
         if (req[(cur + k) % 2]) return (cur + k) % 2;
      return 0;
   endfunction

   // Expected outputs from the model's ownership view and the present inputs
   task automatic check_model();
      int o;
      logic [1:0] tr, er, ep;
      o  = md_owner;
      tr = m_busreq[o] ? b_trans[o] : 2'b00;
      for (int i = 0; i < 2; i++) begin
         er[i] = (i == o || (md_dp_valid && i == md_dp_owner)) ? s_hready : 1'b0;
         ep[i] = (md_dp_valid && i == md_dp_owner) ? s_hresp : 1'b0;
      end
      check("m_hgrant", m_hgrant, 64'(2'b01 << o));
      check("s_htrans", s_htrans, tr);
      check("s_haddr", s_haddr, b_addr[o]);
      check("s_ctrl", {s_hwrite, s_hsize, s_hburst, s_hprot}, {b_write[o], b_size[o], b_burst[o], b_prot[o]});
      check("s_hwdata", s_hwdata, b_wdata[md_dp_owner]);
      check("m_hready", m_hready, er);
      check("m_hresp", m_hresp, ep);
   endtask

   // Apply the arbitration rules for one clock edge
   task automatic model_edge();
      int  o, tr, bu;
      bit  others, pre_incr;
      if (rst) begin
         md_owner = 0; md_dp_owner = 0; md_dp_valid = 0;
         md_beats = 0; md_fixed = 0; md_incr = 0; md_hold = 0;
         return;
      end
      o        = md_owner;
      tr       = m_busreq[o] ? int'(b_trans[o]) : 0;
      bu       = int'(b_burst[o]);
      others   = m_busreq[1 - o];
      pre_incr = md_incr;
      if (s_hready) begin
         if (tr == 2) begin
            md_fixed = (blen[bu] > 1);
            md_incr  = (bu == 1);
            md_beats = md_fixed ? blen[bu] - 1 : 0;
         end else if (tr == 3) begin
            if (md_fixed && md_beats > 0) begin
               md_beats--;
               if (md_beats == 0) md_fixed = 0;
            end
         end else if (tr == 0) begin
            md_incr = 0;
         end
         if (HOLD_EN && pre_incr && others) begin
            if (md_hold + 1 >= HOLD_MAX) md_incr = 0;
            if (md_hold < HOLD_MAX) md_hold++;
         end
         if (tr == 2 || tr == 3) begin
            md_dp_owner = o;
            md_dp_valid = 1;
         end else begin
            md_dp_valid = 0;
         end
         if (!md_fixed && !md_incr) begin
            md_owner = rr_pick(o, m_busreq);
            if (md_owner != o) md_hold = 0;
         end
      end else if (s_hresp) begin
         md_fixed = 0; md_incr = 0; md_beats = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst) check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int err_phase;
      rst = 1'b1; s_hready = 1'b1; s_hresp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_m(i, 1'b1, 2'b10, 3'd3, $urandom, $urandom);
         b_write[i] = 1'b1; b_size[i] = 3'd2; b_prot[i] = 4'h3;
      end
      repeat (2) tick();
      settle();
      check("rst_s_htrans", s_htrans, 2'b00);
      check("rst_s_haddr", s_haddr, 32'd0);
      check("rst_m_hready", m_hready, 2'b11);
      check("rst_m_hresp", m_hresp, 2'b00);
      check("rst_m_hgrant", m_hgrant, 2'b01);

      rst = 1'b0; s_hresp = 1'b0;
      for (int i = 0; i < 2; i++) set_m(i, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
      settle();
      check("idle_grant", m_hgrant, 2'b01);
      check("idle_htrans", s_htrans, 2'b00);
      tick();

      // Both masters issue back-to-back SINGLEs
      set_m(0, 1'b1, 2'b10, 3'd0, 32'h0000_0040, 32'hC0C0_0000);
      set_m(1, 1'b1, 2'b10, 3'd0, 32'h0000_0080, 32'hD0D0_0000);
      for (int k = 0; k < 6; k++) begin
         settle();
         check("alt_grant", m_hgrant, (k % 2) ? 2'b10 : 2'b01);
         tick();
      end

      // DMA INCR4 with a 3-cycle slave stall while the CPU keeps requesting
      set_m(1, 1'b1, 2'b10, 3'd3, 32'h0000_1000, 32'h0);
      for (int w = 0; w < 8 && md_owner != 1; w++) tick();
      check("wait_dma_incr4", md_owner, 1);
      settle();
      check("incr4_b0_addr", s_haddr, 32'h1000);
      tick();
      set_m(1, 1'b1, 2'b11, 3'd3, 32'h0000_1004, 32'hDA7A_0000);
      s_hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("stall_grant", m_hgrant, 2'b10);
         check("stall_cpu_rdy", m_hready[0], 1'b0);
         check("stall_wdata", s_hwdata, 32'hDA7A_0000);
         tick();
      end
      s_hready = 1'b1;
      for (int b = 1; b < 4; b++) begin
         set_m(1, 1'b1, 2'b11, 3'd3, 32'h0000_1000 + 32'(4 * b), 32'hDA7A_0000 + 32'(b - 1));
         settle();
         check("incr4_addr", s_haddr, 32'h0000_1000 + 32'(4 * b));
         check("incr4_grant", m_hgrant, 2'b10);
         tick();
      end
      set_m(1, 1'b1, 2'b00, 3'd3, 32'h0, 32'hDA7A_0003);
      settle();
      check("incr4_handover", m_hgrant, 2'b01);
      check("incr4_last_wdata", s_hwdata, 32'hDA7A_0003);
      check("incr4_last_rdy", m_hready, 2'b11);

      // Two-cycle ERROR on the second beat of a DMA INCR8
      set_m(1, 1'b1, 2'b10, 3'd5, 32'h0000_2000, 32'h0);
      for (int w = 0; w < 8 && md_owner != 1; w++) tick();
      check("wait_dma_incr8", md_owner, 1);
      settle();
      check("incr8_b0_addr", s_haddr, 32'h2000);
      tick();
      set_m(1, 1'b1, 2'b11, 3'd5, 32'h0000_2004, 32'hE000_0000);
      tick();
      set_m(1, 1'b1, 2'b11, 3'd5, 32'h0000_2008, 32'hE000_0001);
      s_hresp = 1'b1; s_hready = 1'b0;
      settle();
      check("err1_hresp", m_hresp, 2'b10);
      tick();
      set_m(1, 1'b1, 2'b00, 3'd5, 32'h0, 32'hE000_0001);
      s_hready = 1'b1;
      settle();
      check("err2_hresp", m_hresp, 2'b10);
      tick();
      s_hresp = 1'b0;
      settle();
      check("err_cpu_grant", m_hgrant, 2'b01);
      check("err_hresp_clear", m_hresp, 2'b00);

      // Undefined-length INCR from the DMA against a waiting CPU
      set_m(1, 1'b1, 2'b10, 3'd1, 32'h0000_3000, 32'h0);
      for (int w = 0; w < 8 && md_owner != 1; w++) tick();
      check("wait_dma_incr", md_owner, 1);
      tick();
      set_m(1, 1'b1, 2'b11, 3'd1, 32'h0000_3004, 32'h3333_0000);
      for (int t = 1; t <= 17; t++) begin
         settle();
         check("incr_hold_grant", m_hgrant, (HOLD_EN && t == 17) ? 2'b01 : 2'b10);
         tick();
      end
      set_m(1, 1'b1, 2'b00, 3'd1, 32'h0, 32'h3333_0001);
      tick();
      settle();
      check("incr_end_grant", m_hgrant, 2'b01);

      // Random traffic, stalls, errors and occasional mid-burst reset
      err_phase = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 2; i++) begin
            m_busreq[i] = ($urandom_range(0, 3) != 0);
            b_trans[i]  = 2'($urandom_range(0, 3));
            b_burst[i]  = 3'($urandom_range(0, 7));
            b_addr[i]   = $urandom;
            b_wdata[i]  = $urandom;
            b_write[i]  = 1'($urandom_range(0, 1));
            b_size[i]   = 3'($urandom_range(0, 2));
            b_prot[i]   = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 99) == 0);
         if (err_phase == 1) begin
            s_hresp = 1'b1; s_hready = 1'b1; err_phase = 0;
         end else if ($urandom_range(0, 24) == 0) begin
            s_hresp = 1'b1; s_hready = 1'b0; err_phase = 1;
         end else begin
            s_hresp = 1'b0; s_hready = ($urandom_range(0, 4) != 0);
         end
         tick();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
